dbg_cmd_tx: RTL and testbench
=============================

# dbg_cmd_tx

Command transmitter at the head of the debug-governor daisy chain. Accepts one register-write request per handshake from a host-side AXI-Stream and serialises it into the two-flit header/data command format on the non-backpressured cmd stream consumed by the first governor's cmd_in port. Enforces a programmable idle gap between commands so chained governors and their PIPE_STAGE registers settle between commands.

## Interface
Parameters:
- DATA_WIDTH, 32, width of cmd flit and of the register value
- ADDR_WIDTH, 10, governor address width
- REG_WIDTH, 4, register-select width
- GAP_CYCLES, 1, idle cycles forced after each command's data flit; 0 is legal
- CNT_SIZE, 16, width of the sent-command counter

Ports:
- clk  in  1  clock; everything samples on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_TDATA  in  ADDR_WIDTH+REG_WIDTH+DATA_WIDTH  request, packed as {addr, reg, value}
- req_TVALID  in  1  request valid
- req_TREADY  out  1  block can accept a request
- cmd_out_TDATA  out  DATA_WIDTH  command flit
- cmd_out_TVALID  out  1  flit valid; no TREADY exists, downstream never stalls
- busy  out  1  high in any state other than IDLE
- sent_count  out  CNT_SIZE  completed commands, wraps modulo 2^CNT_SIZE

## Operation
- States: IDLE, HDR, DATA, GAP.
- IDLE: req_TREADY=1. On req_TVALID&req_TREADY at an edge, register addr/reg/value into holding registers and go to HDR. Otherwise stay.
- HDR: cmd_out_TVALID=1; cmd_out_TDATA[DATA_WIDTH-1 -: ADDR_WIDTH]=addr, [REG_WIDTH-1:0]=reg, all other bits 0. Next state DATA.
- DATA: cmd_out_TVALID=1, cmd_out_TDATA=value. Increment sent_count on exit. Next state GAP if GAP_CYCLES>0, else IDLE.
- GAP: cmd_out_TVALID=0; gap counter loaded with GAP_CYCLES-1 on DATA exit, counts down; at 0 go to IDLE.
- req_TREADY is a registered-state decode (state==IDLE), never combinational from req_TVALID.
- cmd_out_TDATA is driven 0 whenever cmd_out_TVALID=0.
- Holding registers change only on an accepted handshake; req_TDATA changes while busy have no effect.
- Requirement on parameters: ADDR_WIDTH+REG_WIDTH <= DATA_WIDTH; otherwise the header fields overlap. This is a configuration error, and the block does not check for it.

## Timing
- Reset values: state=IDLE, req_TREADY=1, cmd_out_TVALID=0, cmd_out_TDATA=0, busy=0, sent_count=0, gap counter=0.
- Accept at edge k -> header valid in cycle k..k+1, data valid in cycle k+1..k+2, both outputs registered.
- Command period: 3+GAP_CYCLES cycles minimum. The next acceptance can occur at the edge after the last GAP cycle, or after DATA when GAP_CYCLES=0. Back-to-back headers are therefore 3+GAP_CYCLES cycles apart.
- sent_count updates at the edge ending DATA and is visible in the following cycle.
- sent_count wraps from 2^CNT_SIZE-1 to 0 with no flag.
- Reset mid-command: outputs go to reset values immediately (async) and the partial command is dropped.
  - Downstream may therefore see a header with no data; governors must resynchronise on their own reset.
  - sent_count does not count the dropped command.
- req_TVALID dropping before acceptance is tolerated. Only an edge-sampled handshake is accepted.

## Test plan
- Reset, GAP_CYCLES=1: hold req_TVALID=0 -> req_TREADY=1, cmd_out_TVALID=0, sent_count=0 for 10 cycles.
- Single request {addr=1, reg=3, value=0xDEADBEEF}:
  - cmd_out shows 0x00400003 for one cycle, then 0xDEADBEEF for one cycle, then TVALID=0.
  - req_TREADY is low for 3 cycles; sent_count=1.
- Continuous req_TVALID with 4 requests at GAP_CYCLES=1 -> headers exactly 4 cycles apart, payloads in order, sent_count=4.
- GAP_CYCLES=0, continuous requests -> headers 3 cycles apart; TVALID pattern 1,1,0 repeating.
- Assert rst during the DATA cycle -> same-cycle cmd_out_TVALID=0, sent_count unchanged. After release, a new request is sent intact.
- CNT_SIZE=2, send 5 commands -> sent_count sequence 1,2,3,0,1; chain into two governor instances at addresses 0 and 1 and check that only the addressed one updates.

Source files
------------

// File: rtl/dbg_cmd_tx.sv
// -----------------------------------------------------------------------------
// dbg_cmd_tx
//
// Command transmitter at the head of the debug-governor daisy chain. Accepts
// one register-write request per AXI-Stream handshake and serialises it into
// a two-flit command (header, then data) on a stream that never stalls.
// After every data flit a programmable number of idle cycles is inserted so
// downstream governors and their pipeline registers can settle.
//
// Header flit layout:
//   [DATA_WIDTH-1 -: ADDR_WIDTH]  governor address
//   [REG_WIDTH-1:0]               register select
//   all other bits                0
// ADDR_WIDTH+REG_WIDTH must not exceed DATA_WIDTH, or the two fields overlap.
// That configuration is not checked here.
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   req_TDATA       request {addr, reg, value}
//   req_TVALID      request valid
//   req_TREADY      block is idle and can take a request
//   cmd_out_TDATA   command flit, 0 whenever cmd_out_TVALID is low
//   cmd_out_TVALID  flit valid (there is no back-pressure)
//   busy            a command is in flight (any state but IDLE)
//   sent_count      completed commands, wraps modulo 2^CNT_SIZE
// -----------------------------------------------------------------------------
module dbg_cmd_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int REG_WIDTH  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int CNT_SIZE   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [ADDR_WIDTH+REG_WIDTH+DATA_WIDTH-1:0] req_TDATA,
    input  logic                                     req_TVALID,
    output logic                                     req_TREADY,
    output logic [DATA_WIDTH-1:0]                    cmd_out_TDATA,
    output logic                                     cmd_out_TVALID,
    output logic                                     busy,
    output logic [CNT_SIZE-1:0]                      sent_count
);

    localparam int REQ_WIDTH = ADDR_WIDTH + REG_WIDTH + DATA_WIDTH;

    // The gap counter only has to hold GAP_CYCLES-1; keep at least one bit so
    // the design stays legal when GAP_CYCLES is 0, 1 or 2.
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Request fields.
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [REG_WIDTH-1:0]  req_reg;
    logic [DATA_WIDTH-1:0] req_value;

    assign req_addr  = req_TDATA[REQ_WIDTH-1 -: ADDR_WIDTH];
    assign req_reg   = req_TDATA[DATA_WIDTH +: REG_WIDTH];
    assign req_value = req_TDATA[DATA_WIDTH-1:0];

    // State and registered outputs.
    state_e                state_q,      state_d;
    logic [DATA_WIDTH-1:0] value_q,      value_d;
    logic [GAP_W-1:0]      gap_cnt_q,    gap_cnt_d;
    logic                  cmd_valid_q,  cmd_valid_d;
    logic [DATA_WIDTH-1:0] cmd_data_q,   cmd_data_d;
    logic [CNT_SIZE-1:0]   sent_count_q, sent_count_d;

    // Header flit built straight from the incoming request so that it can be
    // registered on the accepting edge. The header register therefore doubles
    // as the holding register for addr/reg; only the value needs its own.
    logic [DATA_WIDTH-1:0] header;

    always_comb begin
        header                              = '0;
        header[DATA_WIDTH-1 -: ADDR_WIDTH]  = req_addr;
        header[REG_WIDTH-1:0]               = req_reg;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default would infer a latch.
        state_d      = state_q;
        value_d      = value_q;
        gap_cnt_d    = gap_cnt_q;
        sent_count_d = sent_count_q;
        // The flit output is idle (valid 0, data 0) unless a state says so.
        cmd_valid_d  = 1'b0;
        cmd_data_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (req_TVALID) begin
                    value_d     = req_value;
                    state_d     = HDR;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = header;
                end
            end

            HDR: begin
                state_d     = DATA;
                cmd_valid_d = 1'b1;
                cmd_data_d  = value_q;
            end

            DATA: begin
                // The data flit is on the wire this cycle; the command is
                // complete at the edge that ends it.
                sent_count_d = sent_count_q + CNT_SIZE'(1);
                if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end

            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            value_q      <= '0;
            gap_cnt_q    <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_data_q   <= '0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            gap_cnt_q    <= gap_cnt_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_data_q   <= cmd_data_d;
            sent_count_q <= sent_count_d;
        end
    end

    // Ready and busy are plain decodes of the registered state, never of
    // req_TVALID, so there is no combinational path from input to ready.
    assign req_TREADY     = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign cmd_out_TVALID = cmd_valid_q;
    assign cmd_out_TDATA  = cmd_data_q;
    assign sent_count     = sent_count_q;

endmodule

// File: tb/tb_dbg_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_dbg_cmd_tx
//
// Three instances of dbg_cmd_tx:
//   u_g1 : GAP_CYCLES=1, CNT_SIZE=16
//   u_g0 : GAP_CYCLES=0, CNT_SIZE=16
//   u_c2 : GAP_CYCLES=2, CNT_SIZE=2, its command stream feeds two governor
//          models at addresses 0 and 1
// Expected behaviour comes from a cycle-schedule model: a request offered in
// cycle c while the block is free produces a header in c+1, data in c+2, the
// count bump in c+3, and frees the block at c+3+GAP.
// -----------------------------------------------------------------------------
module tb_dbg_cmd_tx;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int RW   = 4;
    localparam int REQW = AW + RW + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic            rst       [3];
    logic            req_valid [3];
    logic [REQW-1:0] req_data  [3];

    logic          rdy0, vld0, bsy0, rdy1, vld1, bsy1, rdy2, vld2, bsy2;
    logic [DW-1:0] dat0, dat1, dat2;
    logic [15:0]   cnt0, cnt1;
    logic [1:0]    cnt2;

    dbg_cmd_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW),
                 .GAP_CYCLES(1), .CNT_SIZE(16)) u_g1 (
        .clk(clk), .rst(rst[0]), .req_TDATA(req_data[0]), .req_TVALID(req_valid[0]),
        .req_TREADY(rdy0), .cmd_out_TDATA(dat0), .cmd_out_TVALID(vld0),
        .busy(bsy0), .sent_count(cnt0));

    dbg_cmd_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW),
                 .GAP_CYCLES(0), .CNT_SIZE(16)) u_g0 (
        .clk(clk), .rst(rst[1]), .req_TDATA(req_data[1]), .req_TVALID(req_valid[1]),
        .req_TREADY(rdy1), .cmd_out_TDATA(dat1), .cmd_out_TVALID(vld1),
        .busy(bsy1), .sent_count(cnt1));

    dbg_cmd_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW),
                 .GAP_CYCLES(2), .CNT_SIZE(2)) u_c2 (
        .clk(clk), .rst(rst[2]), .req_TDATA(req_data[2]), .req_TVALID(req_valid[2]),
        .req_TREADY(rdy2), .cmd_out_TDATA(dat2), .cmd_out_TVALID(vld2),
        .busy(bsy2), .sent_count(cnt2));

    // ---------------- accessors -------------------------------------------
    function automatic logic get_rdy(input int idx);
        case (idx) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
    endfunction
    function automatic logic get_vld(input int idx);
        case (idx) 0: return vld0; 1: return vld1; default: return vld2; endcase
    endfunction
    function automatic logic get_bsy(input int idx);
        case (idx) 0: return bsy0; 1: return bsy1; default: return bsy2; endcase
    endfunction
    function automatic logic [DW-1:0] get_dat(input int idx);
        case (idx) 0: return dat0; 1: return dat1; default: return dat2; endcase
    endfunction
    function automatic logic [15:0] get_cnt(input int idx);
        case (idx) 0: return cnt0; 1: return cnt1; default: return {14'b0, cnt2}; endcase
    endfunction
    function automatic int gap_of(input int idx);
        case (idx) 0: return 1; 1: return 0; default: return 2; endcase
    endfunction
    function automatic int cnt_mask(input int idx);
        return (idx == 2) ? 3 : 16'hFFFF;
    endfunction

    function automatic logic [REQW-1:0] mk_req(input int addr, input int rsel, input logic [31:0] val);
        logic [AW-1:0] a;
        logic [RW-1:0] r;
        a = AW'(addr);
        r = RW'(rsel);
        return {a, r, val};
    endfunction

    // Header = address in the top ADDR_WIDTH bits plus register select in the
    // low bits, written as arithmetic on the request fields.
    function automatic logic [31:0] hdr_of(input logic [REQW-1:0] d);
        logic [REQW-1:0] tmp;
        int unsigned     addr;
        int unsigned     rsel;
        tmp  = d;
        addr = int'(tmp >> (RW + DW)) & ((1 << AW) - 1);
        rsel = int'(tmp >> DW) & ((1 << RW) - 1);
        return 32'(addr * (2 ** (DW - AW)) + rsel);
    endfunction

    // ---------------- checking --------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // ---------------- schedule model --------------------------------------
    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          is_data;
    } flit_t;

    flit_t fq[$];
    int    inc_q[$];
    int    next_free [3];
    int    cnt_m     [3];

    // One clock cycle on instance idx: compare outputs with the model for
    // this cycle, then present (v, d) for the edge that ends it.
    task automatic step(input int idx, input logic v, input logic [REQW-1:0] d, output bit acc);
        logic        exp_v;
        logic [31:0] exp_d;
        bit          exp_r;
        flit_t       f;
        @(negedge clk);
        while (inc_q.size() > 0 && inc_q[0] <= cyc_cnt) begin
            void'(inc_q.pop_front());
            cnt_m[idx]++;
        end
        exp_r = (cyc_cnt >= next_free[idx]);
        exp_v = 1'b0;
        exp_d = '0;
        if (fq.size() > 0 && fq[0].cyc == cyc_cnt) begin
            exp_v = 1'b1;
            exp_d = fq[0].data;
            if (fq[0].is_data) inc_q.push_back(cyc_cnt + 1);
            void'(fq.pop_front());
        end
        check($sformatf("u%0d.ready", idx), 64'(get_rdy(idx)), 64'(exp_r));
        check($sformatf("u%0d.busy", idx),  64'(get_bsy(idx)), 64'(!exp_r));
        check($sformatf("u%0d.tvalid", idx), 64'(get_vld(idx)), 64'(exp_v));
        check($sformatf("u%0d.tdata", idx),  64'(get_dat(idx)), 64'(exp_d));
        check($sformatf("u%0d.sent_count", idx), 64'(get_cnt(idx)),
              64'(cnt_m[idx] & cnt_mask(idx)));
        req_valid[idx] = v;
        req_data[idx]  = d;
        acc = v && exp_r;
        if (acc) begin
            f.cyc = cyc_cnt + 1; f.data = hdr_of(d); f.is_data = 1'b0;
            fq.push_back(f);
            f.cyc = cyc_cnt + 2; f.data = d[31:0];   f.is_data = 1'b1;
            fq.push_back(f);
            next_free[idx] = cyc_cnt + 3 + gap_of(idx);
        end
    endtask

    task automatic drain(input int idx);
        bit acc;
        for (int i = 0; i < 40; i++) begin
            if (fq.size() == 0 && inc_q.size() == 0 && cyc_cnt >= next_free[idx]) break;
            step(idx, 1'b0, '0, acc);
        end
        check($sformatf("u%0d.drain", idx), 64'(fq.size() + inc_q.size()), 64'(0));
    endtask

    task automatic random_run(input int idx, input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++)
            step(idx, 1'($urandom_range(0, 1)),
                 mk_req(int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)), $urandom), acc);
        drain(idx);
    endtask

    // ---------------- governor models on u_c2's stream --------------------
    logic [31:0] gov_r0 [16];
    logic [31:0] gov_r1 [16];
    logic        gov_phase;
    logic [9:0]  gov_addr;
    logic [3:0]  gov_reg;

    always @(negedge clk) begin
        if (rst[2]) begin
            gov_phase <= 1'b0;
            gov_addr  <= '0;
            gov_reg   <= '0;
            for (int k = 0; k < 16; k++) begin
                gov_r0[k] <= '0;
                gov_r1[k] <= '0;
            end
        end else if (vld2) begin
            if (!gov_phase) begin
                gov_addr  <= dat2[31:22];
                gov_reg   <= dat2[3:0];
                gov_phase <= 1'b1;
            end else begin
                if (gov_addr == 10'd0) gov_r0[gov_reg] <= dat2;
                if (gov_addr == 10'd1) gov_r1[gov_reg] <= dat2;
                gov_phase <= 1'b0;
            end
        end
    end

    // ---------------- directed table --------------------------------------
    typedef struct {
        logic            v;
        logic [REQW-1:0] d;
        logic            e_rdy;
        logic            e_vld;
        logic [31:0]     e_dat;
        logic [15:0]     e_cnt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit acc;
        int n_acc;
        logic [REQW-1:0] r;
        logic [REQW-1:0] cmds [5];

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_data[i] = '0;
            next_free[i] = 0; cnt_m[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;

        // Idle after reset: 10 cycles of ready, no flits, zero count.
        for (int i = 0; i < 10; i++) step(0, 1'b0, '0, acc);

        // Single request; bus junk presented while busy must be ignored.
        tbl[0] = '{1'b1, mk_req(1, 3, 32'hDEADBEEF), 1'b1, 1'b0, 32'h0,        16'd0};
        tbl[1] = '{1'b1, mk_req(5, 9, 32'hCAFEF00D), 1'b0, 1'b1, 32'h00400003, 16'd0};
        tbl[2] = '{1'b1, mk_req(7, 1, 32'h12345678), 1'b0, 1'b1, 32'hDEADBEEF, 16'd0};
        tbl[3] = '{1'b0, '0,                         1'b0, 1'b0, 32'h0,        16'd1};
        tbl[4] = '{1'b0, '0,                         1'b1, 1'b0, 32'h0,        16'd1};
        tbl[5] = '{1'b0, '0,                         1'b1, 1'b0, 32'h0,        16'd1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("tbl%0d.ready", i),  64'(rdy0), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d.tvalid", i), 64'(vld0), 64'(tbl[i].e_vld));
            check($sformatf("tbl%0d.tdata", i),  64'(dat0), 64'(tbl[i].e_dat));
            check($sformatf("tbl%0d.count", i),  64'(cnt0), 64'(tbl[i].e_cnt));
            req_valid[0] = tbl[i].v;
            req_data[0]  = tbl[i].d;
        end
        cnt_m[0] = 1;

        // Continuous valid, four requests, GAP_CYCLES=1.
        n_acc = 0;
        for (int i = 0; i < 40 && n_acc < 4; i++) begin
            step(0, 1'b1, mk_req(int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)), $urandom), acc);
            if (acc) n_acc++;
        end
        check("cont4.accepts", 64'(n_acc), 64'(4));
        drain(0);
        check("cont4.count", 64'(cnt0), 64'(5));

        random_run(0, 150);

        // Reset during the DATA cycle of u_g0 (count still 0).
        r = mk_req(2, 6, 32'hA5A5A5A5);
        @(negedge clk);
        check("rstmid.ready", 64'(rdy1), 64'(1));
        req_valid[1] = 1'b1; req_data[1] = r;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rstmid.hdr", 64'(dat1), 64'(hdr_of(r)));
        @(negedge clk);
        check("rstmid.data_valid", 64'(vld1), 64'(1));
        rst[1] = 1'b1;
        #1;
        check("rstmid.tvalid", 64'(vld1), 64'(0));
        check("rstmid.tdata",  64'(dat1), 64'(0));
        check("rstmid.count",  64'(cnt1), 64'(0));
        check("rstmid.ready",  64'(rdy1), 64'(1));
        @(negedge clk);
        rst[1] = 1'b0;
        step(1, 1'b1, mk_req(3, 4, 32'h0BADF00D), acc);
        check("rstmid.reaccept", 64'(acc), 64'(1));
        drain(1);
        check("rstmid.count_after", 64'(cnt1), 64'(1));

        // GAP_CYCLES=0 continuous, then random.
        for (int i = 0; i < 12; i++)
            step(1, 1'b1, mk_req(int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)), $urandom), acc);
        drain(1);
        random_run(1, 150);

        // CNT_SIZE=2: five commands into governors at addresses 0 and 1.
        cmds[0] = mk_req(0, 2, 32'h1000_0000);
        cmds[1] = mk_req(1, 5, 32'h1000_0001);
        cmds[2] = mk_req(0, 5, 32'h1000_0002);
        cmds[3] = mk_req(1, 9, 32'h1000_0003);
        cmds[4] = mk_req(0, 2, 32'h1000_0004);
        for (int c = 0; c < 5; c++) begin
            acc = 1'b0;
            for (int i = 0; i < 10 && !acc; i++) step(2, 1'b1, cmds[c], acc);
            check($sformatf("gov.accept%0d", c), 64'(acc), 64'(1));
        end
        drain(2);
        check("c2.count_wrap", 64'(cnt2), 64'(1));
        check("gov0.r2", 64'(gov_r0[2]), 64'(32'h1000_0004));
        check("gov0.r5", 64'(gov_r0[5]), 64'(32'h1000_0002));
        check("gov0.r9", 64'(gov_r0[9]), 64'(0));
        check("gov1.r5", 64'(gov_r1[5]), 64'(32'h1000_0001));
        check("gov1.r9", 64'(gov_r1[9]), 64'(32'h1000_0003));
        check("gov1.r2", 64'(gov_r1[2]), 64'(0));

        random_run(2, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc_cnt);
        $fatal(1, "timeout");
    end

endmodule
